// File: rtl/gx_rst_ctrl_xn_if.sv
// Reset-sequencer bundle: soft requests and GX status toward the sequencer, per-channel resets and readies back.
interface gx_rst_ctrl_xn_if #(
    parameter int unsigned N_CH = 2
);
    logic [N_CH-1:0] tx_reset_req;
    logic [N_CH-1:0] rx_reset_req;
    logic [N_CH-1:0] pll_locked;
    logic [N_CH-1:0] tx_cal_busy;
    logic [N_CH-1:0] rx_cal_busy;
    logic [N_CH-1:0] rx_is_lockedtodata;
    logic [N_CH-1:0] tx_analogreset;
    logic [N_CH-1:0] tx_digitalreset;
    logic [N_CH-1:0] rx_analogreset;
    logic [N_CH-1:0] rx_digitalreset;
    logic [N_CH-1:0] tx_ready;
    logic [N_CH-1:0] rx_ready;

    modport master (
        input  tx_reset_req, rx_reset_req, pll_locked, tx_cal_busy, rx_cal_busy, rx_is_lockedtodata,
        output tx_analogreset, tx_digitalreset, rx_analogreset, rx_digitalreset, tx_ready, rx_ready
    );

    modport slave (
        output tx_reset_req, rx_reset_req, pll_locked, tx_cal_busy, rx_cal_busy, rx_is_lockedtodata,
        input  tx_analogreset, tx_digitalreset, rx_analogreset, rx_digitalreset, tx_ready, rx_ready
    );
endinterface

// File: rtl/gx_rst_ctrl_xn.sv
// N-channel GX reset sequencer: independent TX and RX state machines per channel,
// driven by synchronised PLL/calibration/CDR status, with registered reset outputs.
module gx_rst_ctrl_xn #(
    parameter int unsigned N_CH          = 2,
    parameter int unsigned T_RST         = 64,
    parameter int unsigned T_DIG         = 256,
    parameter int unsigned T_LTD         = 1024,
    parameter int unsigned T_LTD_TIMEOUT = 65536
) (
    input  logic              reconfig_clk,
    input  logic              reconfig_reset,
    gx_rst_ctrl_xn_if.master  gx
);
    localparam int unsigned TX_MAX = (T_RST > T_DIG) ? T_RST : T_DIG;
    localparam int unsigned RX_MAX = (T_RST > T_LTD_TIMEOUT) ? T_RST : T_LTD_TIMEOUT;
    localparam int unsigned TX_CW  = $clog2(TX_MAX) + 1;
    localparam int unsigned RX_CW  = $clog2(RX_MAX) + 1;
    localparam int unsigned STB_CW = $clog2(T_LTD) + 1;

    typedef enum logic [1:0] {TX_RESET, TX_WAIT_CAL, TX_ANA_REL, TX_READY} tx_state_t;
    typedef enum logic [1:0] {RX_RESET, RX_WAIT_CAL, RX_WAIT_LTD, RX_READY} rx_state_t;

    logic [N_CH-1:0] pll_meta, pll_s;
    logic [N_CH-1:0] tx_cal_meta, tx_cal_s;
    logic [N_CH-1:0] rx_cal_meta, rx_cal_s;
    logic [N_CH-1:0] ltd_meta, ltd_s;

    tx_state_t        tx_state_q [N_CH];
    tx_state_t        tx_state_d [N_CH];
    rx_state_t        rx_state_q [N_CH];
    rx_state_t        rx_state_d [N_CH];
    logic [TX_CW-1:0]  tx_cnt_q  [N_CH];
    logic [TX_CW-1:0]  tx_cnt_d  [N_CH];
    logic [RX_CW-1:0]  rx_cnt_q  [N_CH];
    logic [RX_CW-1:0]  rx_cnt_d  [N_CH];
    logic [STB_CW-1:0] stb_cnt_q [N_CH];
    logic [STB_CW-1:0] stb_cnt_d [N_CH];

    logic [N_CH-1:0] tx_ana_d, tx_dig_d, tx_rdy_d;
    logic [N_CH-1:0] rx_ana_d, rx_dig_d, rx_rdy_d;

    // Two-flop synchronisers for the asynchronous status inputs; intentionally not reset.
    always_ff @(posedge reconfig_clk) begin
        pll_meta    <= gx.pll_locked;
        pll_s       <= pll_meta;
        tx_cal_meta <= gx.tx_cal_busy;
        tx_cal_s    <= tx_cal_meta;
        rx_cal_meta <= gx.rx_cal_busy;
        rx_cal_s    <= rx_cal_meta;
        ltd_meta    <= gx.rx_is_lockedtodata;
        ltd_s       <= ltd_meta;
    end

    // Next-state, counter and output decode for every channel.
    always_comb begin
        tx_ana_d = '0;
        tx_dig_d = '0;
        tx_rdy_d = '0;
        rx_ana_d = '0;
        rx_dig_d = '0;
        rx_rdy_d = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            tx_state_d[i] = tx_state_q[i];
            rx_state_d[i] = rx_state_q[i];
            tx_cnt_d[i]   = '0;
            rx_cnt_d[i]   = '0;
            stb_cnt_d[i]  = '0;

            if (gx.tx_reset_req[i]) begin
                tx_state_d[i] = TX_RESET;
            end else begin
                case (tx_state_q[i])
                    TX_RESET:    if (tx_cnt_q[i] == TX_CW'(T_RST - 1)) tx_state_d[i] = TX_WAIT_CAL;
                    TX_WAIT_CAL: if (pll_s[i] && !tx_cal_s[i]) tx_state_d[i] = TX_ANA_REL;
                    TX_ANA_REL: begin
                        if (!pll_s[i])                              tx_state_d[i] = TX_RESET;
                        else if (tx_cnt_q[i] == TX_CW'(T_DIG - 1))  tx_state_d[i] = TX_READY;
                    end
                    TX_READY:    if (!pll_s[i]) tx_state_d[i] = TX_RESET;
                endcase
            end

            if (gx.rx_reset_req[i]) begin
                rx_state_d[i] = RX_RESET;
            end else begin
                case (rx_state_q[i])
                    RX_RESET:    if (rx_cnt_q[i] == RX_CW'(T_RST - 1)) rx_state_d[i] = RX_WAIT_CAL;
                    RX_WAIT_CAL: if (!rx_cal_s[i]) rx_state_d[i] = RX_WAIT_LTD;
                    RX_WAIT_LTD: begin
                        if (ltd_s[i] && stb_cnt_q[i] == STB_CW'(T_LTD - 1))  rx_state_d[i] = RX_READY;
                        else if (rx_cnt_q[i] == RX_CW'(T_LTD_TIMEOUT - 1))  rx_state_d[i] = RX_RESET;
                    end
                    RX_READY: begin
                        if (rx_cal_s[i])    rx_state_d[i] = RX_RESET;
                        else if (!ltd_s[i]) rx_state_d[i] = RX_WAIT_LTD;
                    end
                endcase
            end

            // Counters restart on state entry (and while a request holds the FSM), otherwise saturate.
            if (tx_state_d[i] == tx_state_q[i] && !gx.tx_reset_req[i])
                tx_cnt_d[i] = (tx_cnt_q[i] == '1) ? tx_cnt_q[i] : tx_cnt_q[i] + TX_CW'(1);
            if (rx_state_d[i] == rx_state_q[i] && !gx.rx_reset_req[i])
                rx_cnt_d[i] = (rx_cnt_q[i] == '1) ? rx_cnt_q[i] : rx_cnt_q[i] + RX_CW'(1);
            if (rx_state_d[i] == rx_state_q[i] && ltd_s[i])
                stb_cnt_d[i] = (stb_cnt_q[i] == '1) ? stb_cnt_q[i] : stb_cnt_q[i] + STB_CW'(1);

            tx_ana_d[i] = (tx_state_d[i] == TX_RESET) || (tx_state_d[i] == TX_WAIT_CAL);
            tx_dig_d[i] = (tx_state_d[i] != TX_READY);
            tx_rdy_d[i] = (tx_state_d[i] == TX_READY);
            rx_ana_d[i] = (rx_state_d[i] == RX_RESET) || (rx_state_d[i] == RX_WAIT_CAL);
            rx_dig_d[i] = (rx_state_d[i] != RX_READY);
            rx_rdy_d[i] = (rx_state_d[i] == RX_READY);
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge reconfig_clk) begin
        if (reconfig_reset) begin
            for (int i = 0; i < int'(N_CH); i++) begin
                tx_state_q[i] <= TX_RESET;
                rx_state_q[i] <= RX_RESET;
                tx_cnt_q[i]   <= '0;
                rx_cnt_q[i]   <= '0;
                stb_cnt_q[i]  <= '0;
            end
            gx.tx_analogreset  <= '1;
            gx.tx_digitalreset <= '1;
            gx.rx_analogreset  <= '1;
            gx.rx_digitalreset <= '1;
            gx.tx_ready        <= '0;
            gx.rx_ready        <= '0;
        end else begin
            for (int i = 0; i < int'(N_CH); i++) begin
                tx_state_q[i] <= tx_state_d[i];
                rx_state_q[i] <= rx_state_d[i];
                tx_cnt_q[i]   <= tx_cnt_d[i];
                rx_cnt_q[i]   <= rx_cnt_d[i];
                stb_cnt_q[i]  <= stb_cnt_d[i];
            end
            gx.tx_analogreset  <= tx_ana_d;
            gx.tx_digitalreset <= tx_dig_d;
            gx.rx_analogreset  <= rx_ana_d;
            gx.rx_digitalreset <= rx_dig_d;
            gx.tx_ready        <= tx_rdy_d;
            gx.rx_ready        <= rx_rdy_d;
        end
    end
endmodule

// File: tb/tb_gx_rst_ctrl_xn.sv
// Directed bench for gx_rst_ctrl_xn with short timing parameters; expected edges are hand-counted
// from the reset-sampling edge (E0) through the two-flop synchronisers and registered outputs.
module tb_gx_rst_ctrl_xn;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    gx_rst_ctrl_xn_if #(.N_CH(2)) gx ();

    gx_rst_ctrl_xn #(
        .N_CH(2), .T_RST(4), .T_DIG(8), .T_LTD(16), .T_LTD_TIMEOUT(64)
    ) dut (
        .reconfig_clk   (clk),
        .reconfig_reset (rst),
        .gx             (gx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Full bring-up from the last reset-sampled edge, all status good.
    task automatic bringup(input string p);
        tick(4);
        chk({p, "tx_ana_e4"}, gx.tx_analogreset, 2'b11);
        chk({p, "rx_ana_e4"}, gx.rx_analogreset, 2'b11);
        tick(1);
        chk({p, "tx_ana_e5"}, gx.tx_analogreset, 2'b00);
        chk({p, "rx_ana_e5"}, gx.rx_analogreset, 2'b00);
        chk({p, "tx_dig_e5"}, gx.tx_digitalreset, 2'b11);
        chk({p, "rx_dig_e5"}, gx.rx_digitalreset, 2'b11);
        tick(7);
        chk({p, "tx_rdy_e12"}, gx.tx_ready, 2'b00);
        chk({p, "tx_dig_e12"}, gx.tx_digitalreset, 2'b11);
        tick(1);
        chk({p, "tx_rdy_e13"}, gx.tx_ready, 2'b11);
        chk({p, "tx_dig_e13"}, gx.tx_digitalreset, 2'b00);
        tick(7);
        chk({p, "rx_rdy_e20"}, gx.rx_ready, 2'b00);
        chk({p, "rx_dig_e20"}, gx.rx_digitalreset, 2'b11);
        tick(1);
        chk({p, "rx_rdy_e21"}, gx.rx_ready, 2'b11);
        chk({p, "rx_dig_e21"}, gx.rx_digitalreset, 2'b00);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst                   = 1'b1;
        gx.tx_reset_req       = 2'b00;
        gx.rx_reset_req       = 2'b00;
        gx.pll_locked         = 2'b11;
        gx.tx_cal_busy        = 2'b00;
        gx.rx_cal_busy        = 2'b00;
        gx.rx_is_lockedtodata = 2'b11;
        tick(3);

        // Reset state
        chk("rst_tx_ana", gx.tx_analogreset, 2'b11);
        chk("rst_tx_dig", gx.tx_digitalreset, 2'b11);
        chk("rst_rx_ana", gx.rx_analogreset, 2'b11);
        chk("rst_rx_dig", gx.rx_digitalreset, 2'b11);
        chk("rst_tx_rdy", gx.tx_ready, 2'b00);
        chk("rst_rx_rdy", gx.rx_ready, 2'b00);
        rst = 1'b0;
        bringup("bu1_");

        // Calibration hold on ch0 TX
        gx.tx_cal_busy = 2'b01;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(13);
        chk("cal_tx_rdy_e13", gx.tx_ready, 2'b10);
        chk("cal_tx_ana_e13", gx.tx_analogreset, 2'b01);
        tick(8);
        chk("cal_rx_rdy_e21", gx.rx_ready, 2'b11);
        tick(79);
        gx.tx_cal_busy = 2'b00;
        tick(2);
        chk("cal_tx_ana_e102", gx.tx_analogreset, 2'b01);
        tick(1);
        chk("cal_tx_ana_e103", gx.tx_analogreset, 2'b00);
        tick(7);
        chk("cal_tx_rdy_e110", gx.tx_ready, 2'b10);
        tick(1);
        chk("cal_tx_rdy_e111", gx.tx_ready, 2'b11);

        // One-cycle CDR glitch on ch1
        gx.rx_is_lockedtodata = 2'b01;
        tick(1);
        gx.rx_is_lockedtodata = 2'b11;
        tick(1);
        chk("cdr_rx_rdy_a2", gx.rx_ready, 2'b11);
        tick(1);
        chk("cdr_rx_rdy_a3", gx.rx_ready, 2'b01);
        chk("cdr_rx_dig_a3", gx.rx_digitalreset, 2'b10);
        chk("cdr_rx_ana_a3", gx.rx_analogreset, 2'b00);
        tick(15);
        chk("cdr_rx_rdy_a18", gx.rx_ready, 2'b01);
        chk("cdr_rx_ana_a18", gx.rx_analogreset, 2'b00);
        tick(1);
        chk("cdr_rx_rdy_a19", gx.rx_ready, 2'b11);
        chk("cdr_tx_rdy", gx.tx_ready, 2'b11);

        // Soft TX request on ch0, then again mid TX_ANA_REL
        gx.tx_reset_req = 2'b01;
        tick(1);
        gx.tx_reset_req = 2'b00;
        chk("req_tx_ana_b1", gx.tx_analogreset, 2'b01);
        chk("req_tx_rdy_b1", gx.tx_ready, 2'b10);
        tick(7);
        chk("req_tx_ana_b8", gx.tx_analogreset, 2'b00);
        chk("req_tx_dig_b8", gx.tx_digitalreset, 2'b01);
        gx.tx_reset_req = 2'b01;
        tick(1);
        gx.tx_reset_req = 2'b00;
        chk("req_tx_ana_c0", gx.tx_analogreset, 2'b01);
        tick(4);
        chk("req_tx_ana_c4", gx.tx_analogreset, 2'b01);
        tick(1);
        chk("req_tx_ana_c5", gx.tx_analogreset, 2'b00);
        tick(7);
        chk("req_tx_rdy_c12", gx.tx_ready, 2'b10);
        tick(1);
        chk("req_tx_rdy_c13", gx.tx_ready, 2'b11);
        chk("req_rx_rdy", gx.rx_ready, 2'b11);

        // RX request held for 10 cycles on ch1
        gx.rx_reset_req = 2'b10;
        tick(1);
        chk("rreq_rx_ana_d1", gx.rx_analogreset, 2'b10);
        chk("rreq_rx_rdy_d1", gx.rx_ready, 2'b01);
        tick(9);
        gx.rx_reset_req = 2'b00;
        chk("rreq_rx_ana_d10", gx.rx_analogreset, 2'b10);
        tick(4);
        chk("rreq_rx_ana_d14", gx.rx_analogreset, 2'b10);
        tick(1);
        chk("rreq_rx_ana_d15", gx.rx_analogreset, 2'b00);
        tick(15);
        chk("rreq_rx_rdy_d30", gx.rx_ready, 2'b01);
        tick(1);
        chk("rreq_rx_rdy_d31", gx.rx_ready, 2'b11);
        chk("rreq_tx_rdy", gx.tx_ready, 2'b11);

        // Lock timeout on ch0: lockedtodata toggles every 8 cycles
        for (int cyc = 1; cyc <= 140; cyc++) begin
            gx.rx_is_lockedtodata[0] = (((cyc - 1) / 8) % 2) == 1;
            tick(1);
            if (cyc == 2) chk("to_rx_rdy_2", gx.rx_ready, 2'b11);
            if (cyc >= 3) chk("to_rx_rdy_low", gx.rx_ready, 2'b10);
            if (cyc == 3 || cyc == 66 || cyc == 72 || cyc == 135)
                chk("to_rx_ana_low", gx.rx_analogreset, 2'b00);
            if (cyc == 67 || cyc == 71 || cyc == 136)
                chk("to_rx_ana_high", gx.rx_analogreset, 2'b01);
        end
        gx.rx_is_lockedtodata = 2'b11;
        tick(100);
        chk("rec_tx_rdy", gx.tx_ready, 2'b11);
        chk("rec_rx_rdy", gx.rx_ready, 2'b11);

        // reconfig_reset while READY, then repeat bring-up
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("rr_tx_ana", gx.tx_analogreset, 2'b11);
        chk("rr_tx_dig", gx.tx_digitalreset, 2'b11);
        chk("rr_rx_ana", gx.rx_analogreset, 2'b11);
        chk("rr_rx_dig", gx.rx_digitalreset, 2'b11);
        chk("rr_tx_rdy", gx.tx_ready, 2'b00);
        chk("rr_rx_rdy", gx.rx_ready, 2'b00);
        bringup("bu2_");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
